// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a read-only fetch port and an MMU
// load/store port, with a fetch starvation guard and a memory-ack timeout.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_grant,
  output logic                  i_data_valid,
  output logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  d_req_valid,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wrt_data,
  output logic                  d_grant,
  output logic                  d_data_valid,
  output logic [DATA_WIDTH-1:0] d_rd_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  bus_err,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TIMER_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
  localparam bit         TIMER_EN   = (TIMEOUT != 0);

  state_t                r_state;
  logic                  r_owner;
  logic [3:0]            r_starve;
  logic [7:0]            r_timer;
  logic                  w_any_req;
  logic                  w_fetch_wins;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_capture;

  assign w_any_req    = i_req_valid | d_req_valid;
  assign w_fetch_wins = i_req_valid & (~d_req_valid | (r_starve == STARVE_MAX));
  assign w_timeout    = TIMER_EN && (r_timer == TIMER_LAST);
  // Stores and aborted transactions return zero; mem_we is the latched enable.
  assign w_capture    = (mem_ack && !mem_we) ? mem_rdata : '0;

  // Memory port outputs double as the request latches while BUSY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_starve     <= '0;
      r_timer      <= '0;
      i_grant      <= 1'b0;
      i_data_valid <= 1'b0;
      i_rd_data    <= '0;
      d_grant      <= 1'b0;
      d_data_valid <= 1'b0;
      d_rd_data    <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      bus_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      i_grant      <= 1'b0;
      d_grant      <= 1'b0;
      i_data_valid <= 1'b0;
      d_data_valid <= 1'b0;
      bus_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_BUSY;
            busy    <= 1'b1;
            mem_req <= 1'b1;
            r_timer <= '0;
            if (w_fetch_wins) begin
              r_owner   <= 1'b0;
              i_grant   <= 1'b1;
              r_starve  <= '0;
              mem_addr  <= i_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end else begin
              r_owner   <= 1'b1;
              d_grant   <= 1'b1;
              r_starve  <= i_req_valid ? r_starve + 4'd1 : 4'd0;
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_we ? d_wrt_data : '0;
            end
          end
        end
        S_BUSY: begin
          r_timer <= r_timer + 8'd1;
          if (mem_ack || w_timeout) begin
            r_state   <= S_DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            bus_err   <= ~mem_ack;
            if (r_owner) begin
              d_data_valid <= 1'b1;
              d_rd_data    <= w_capture;
            end else begin
              i_data_valid <= 1'b1;
              i_rd_data    <= w_capture;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions on mem_arbiter, checked
// against a transaction-level model of arbitration, latency and returned data.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req_valid = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_grant, i_data_valid;
  logic [DW-1:0] i_rd_data;
  logic          d_req_valid = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wrt_data = '0;
  logic          d_grant, d_data_valid;
  logic [DW-1:0] d_rd_data;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          bus_err, busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: consecutive data wins while fetch waits, last read data per port.
  int          modelStarve = 0;
  logic [31:0] lastI = '0;
  logic [31:0] lastD = '0;

  typedef struct {
    logic        iGrant, dGrant, memWe;
    logic [31:0] memAddr, memWdata;
    int          reqCycles;
    logic        iDv, dDv, busErr, busyDone;
    logic [31:0] iRd, dRd;
    int          extraGrants;
    logic        idleDirty;
  } obs_t;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_addr(i_addr), .i_grant(i_grant),
    .i_data_valid(i_data_valid), .i_rd_data(i_rd_data),
    .d_req_valid(d_req_valid), .d_we(d_we), .d_addr(d_addr), .d_wrt_data(d_wrt_data),
    .d_grant(d_grant), .d_data_valid(d_data_valid), .d_rd_data(d_rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 when the data port should win, and advances the starvation model.
  function automatic bit modelArbitrate(input bit ireq, input bit dreq);
    bit fetchWins;
    fetchWins = ireq && (!dreq || modelStarve == SL);
    if (fetchWins) modelStarve = 0;
    else modelStarve = ireq ? modelStarve + 1 : 0;
    return !fetchWins;
  endfunction

  // Memory responds after ackWait stall cycles; records what the DUT showed.
  task automatic observeTxn(input int ackWait, input logic [31:0] rdata, input bit holdReq,
                            output obs_t o);
    int cyc;
    o = '{default: 0};
    tick();
    if (!holdReq) begin
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
    end
    o.iGrant = i_grant; o.dGrant = d_grant; o.memWe = mem_we;
    o.memAddr = mem_addr; o.memWdata = mem_wdata;
    cyc = 0;
    while (mem_req === 1'b1 && cyc < 40) begin
      cyc++;
      mem_ack = (cyc == ackWait + 1);
      mem_rdata = rdata;
      tick();
      mem_ack = 1'b0;
      o.extraGrants += (i_grant ? 1 : 0) + (d_grant ? 1 : 0);
    end
    o.reqCycles = cyc;
    o.iDv = i_data_valid; o.dDv = d_data_valid; o.busErr = bus_err;
    o.iRd = i_rd_data; o.dRd = d_rd_data; o.busyDone = busy;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    tick();
    mem_ack = 1'b0;
    o.extraGrants += (i_grant ? 1 : 0) + (d_grant ? 1 : 0);
    o.idleDirty = busy | mem_req | i_data_valid | d_data_valid | bus_err;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    vectors++;
    if ({i_grant, i_data_valid, i_rd_data, d_grant, d_data_valid, d_rd_data, mem_req, mem_we,
         mem_addr, mem_wdata, bus_err, busy} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: observed nonzero output, expected all 0 (busy=%b mem_req=%b)", busy, mem_req);
    end
    d_req_valid = 1'b1;
    mem_ack = 1'b1;
    tick();
    tick();
    vectors++;
    if ({d_grant, mem_req, busy} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: grant/req/busy=%b, expected 000", {d_grant, mem_req, busy});
    end
    d_req_valid = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    modelStarve = 0; lastI = '0; lastD = '0;
  endtask

  task automatic test_load();
    obs_t o;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wrt_data = 32'h5555_AAAA;
    void'(modelArbitrate(1'b0, 1'b1));
    lastD = 32'hDEADBEEF;
    observeTxn(2, 32'hDEADBEEF, 1'b1, o);
    d_req_valid = 1'b0;
    vectors++; if ({o.iGrant, o.dGrant} !== 2'b01) begin miscompares++; $display("[TB] FAIL load_grant: got %b, expected 01", {o.iGrant, o.dGrant}); end
    vectors++; if (o.memAddr !== 32'h100 || o.memWe !== 1'b0) begin miscompares++; $display("[TB] FAIL load_addr: got %h we=%b, expected 00000100 we=0", o.memAddr, o.memWe); end
    vectors++; if (o.reqCycles != 3) begin miscompares++; $display("[TB] FAIL load_req_cycles: got %0d, expected 3", o.reqCycles); end
    vectors++; if ({o.iDv, o.dDv, o.busErr} !== 3'b010) begin miscompares++; $display("[TB] FAIL load_valid: iDv,dDv,err=%b, expected 010", {o.iDv, o.dDv, o.busErr}); end
    vectors++; if (o.dRd !== lastD || o.iRd !== lastI) begin miscompares++; $display("[TB] FAIL load_data: d=%h i=%h, expected d=%h i=%h", o.dRd, o.iRd, lastD, lastI); end
    vectors++; if (o.extraGrants != 0) begin miscompares++; $display("[TB] FAIL load_single_grant: %0d extra grants while held, expected 0", o.extraGrants); end
    vectors++; if (o.busyDone !== 1'b1 || o.idleDirty !== 1'b0) begin miscompares++; $display("[TB] FAIL load_busy: done=%b idleDirty=%b, expected 1/0", o.busyDone, o.idleDirty); end
  endtask

  task automatic test_store();
    obs_t o;
    d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wrt_data = 32'h12345678;
    void'(modelArbitrate(1'b0, 1'b1));
    lastD = '0;
    observeTxn(0, 32'hFFFF0000, 1'b0, o);
    d_we = 1'b0;
    vectors++; if (o.memWe !== 1'b1 || o.memWdata !== 32'h12345678 || o.memAddr !== 32'h40) begin miscompares++; $display("[TB] FAIL store_bus: we=%b wdata=%h addr=%h, expected 1 12345678 00000040", o.memWe, o.memWdata, o.memAddr); end
    vectors++; if (o.reqCycles != 1) begin miscompares++; $display("[TB] FAIL store_req_cycles: got %0d, expected 1", o.reqCycles); end
    vectors++; if (o.dDv !== 1'b1 || o.dRd !== 32'h0) begin miscompares++; $display("[TB] FAIL store_ack: dDv=%b dRd=%h, expected 1 00000000", o.dDv, o.dRd); end
  endtask

  task automatic test_starvation();
    obs_t o;
    logic [9:0] expectData;
    logic [9:0] gotData;
    expectData = 10'b1111011110;
    gotData = '0;
    i_req_valid = 1'b1; d_req_valid = 1'b1; d_we = 1'b0;
    for (int n = 0; n < 10; n++) begin
      bit dataWins;
      logic [31:0] rd;
      i_addr = $urandom; d_addr = $urandom; rd = $urandom;
      dataWins = modelArbitrate(1'b1, 1'b1);
      if (dataWins) lastD = rd; else lastI = rd;
      observeTxn(0, rd, 1'b1, o);
      gotData[9-n] = o.dGrant;
      vectors++; if ((o.iGrant ^ o.dGrant) !== 1'b1 || o.reqCycles != 1) begin miscompares++; $display("[TB] FAIL starve_txn%0d: grants=%b cycles=%0d, expected one grant and 1 cycle", n, {o.iGrant, o.dGrant}, o.reqCycles); end
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    vectors++; if (gotData !== expectData) begin miscompares++; $display("[TB] FAIL starve_sequence: data-grant pattern %b, expected %b", gotData, expectData); end
  endtask

  task automatic test_timeout();
    obs_t o;
    i_req_valid = 1'b1; i_addr = 32'h0000_2000;
    void'(modelArbitrate(1'b1, 1'b0));
    lastI = '0;
    observeTxn(100, 32'h1111_2222, 1'b0, o);
    vectors++; if (o.reqCycles != TO) begin miscompares++; $display("[TB] FAIL timeout_req_cycles: got %0d, expected %0d", o.reqCycles, TO); end
    vectors++; if ({o.iDv, o.dDv, o.busErr} !== 3'b101) begin miscompares++; $display("[TB] FAIL timeout_flags: iDv,dDv,err=%b, expected 101", {o.iDv, o.dDv, o.busErr}); end
    vectors++; if (o.iRd !== 32'h0 || o.idleDirty !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_data: iRd=%h idleDirty=%b, expected 0/0", o.iRd, o.idleDirty); end
  endtask

  task automatic test_collision();
    obs_t o;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0ABC;
    void'(modelArbitrate(1'b0, 1'b1));
    lastD = 32'hA5;
    observeTxn(TO - 1, 32'hA5, 1'b0, o);
    vectors++; if (o.reqCycles != TO) begin miscompares++; $display("[TB] FAIL collide_req_cycles: got %0d, expected %0d", o.reqCycles, TO); end
    vectors++; if (o.dRd !== 32'hA5 || o.busErr !== 1'b0 || o.dDv !== 1'b1) begin miscompares++; $display("[TB] FAIL collide_result: dRd=%h err=%b dDv=%b, expected 000000a5 0 1", o.dRd, o.busErr, o.dDv); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int stray;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    tick();
    d_req_valid = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({i_grant, i_data_valid, i_rd_data, d_grant, d_data_valid, d_rd_data, mem_req, mem_we,
         mem_addr, mem_wdata, bus_err, busy} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: busy=%b mem_req=%b addr=%h, expected all 0", busy, mem_req, mem_addr);
    end
    modelStarve = 0; lastI = '0; lastD = '0;
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    stray = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      stray += (d_data_valid | i_data_valid | mem_req | busy) ? 1 : 0;
    end
    mem_ack = 1'b0;
    vectors++; if (stray != 0) begin miscompares++; $display("[TB] FAIL midreset_stray: %0d active cycles after reset, expected 0", stray); end
    d_req_valid = 1'b1; d_addr = 32'h0000_0304;
    void'(modelArbitrate(1'b0, 1'b1));
    lastD = 32'hCAFEF00D;
    observeTxn(1, 32'hCAFEF00D, 1'b0, o);
    vectors++; if (o.dGrant !== 1'b1 || o.memAddr !== 32'h304 || o.reqCycles != 2) begin miscompares++; $display("[TB] FAIL midreset_regrant: grant=%b addr=%h cycles=%0d, expected 1 00000304 2", o.dGrant, o.memAddr, o.reqCycles); end
    vectors++; if (o.dRd !== 32'hCAFEF00D || o.dDv !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_data: dRd=%h dDv=%b, expected cafef00d 1", o.dRd, o.dDv); end
  endtask

  task automatic test_random();
    obs_t o;
    for (int n = 0; n < 40; n++) begin
      bit          ireq, dreq, dataWins, expWe, expErr;
      int          ackWait, expCycles;
      logic [31:0] rd, expAddr, expWdata;
      ireq = 1'($urandom_range(0, 1));
      dreq = ireq ? 1'($urandom_range(0, 1)) : 1'b1;
      i_addr = $urandom; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wrt_data = $urandom;
      ackWait = $urandom_range(0, 10);
      rd = $urandom;
      i_req_valid = ireq; d_req_valid = dreq;
      dataWins = modelArbitrate(ireq, dreq);
      expWe = dataWins && d_we;
      expAddr = dataWins ? d_addr : i_addr;
      expWdata = expWe ? d_wrt_data : 32'h0;
      expErr = (ackWait >= TO);
      expCycles = expErr ? TO : ackWait + 1;
      if (dataWins) lastD = (expErr || expWe) ? 32'h0 : rd;
      else lastI = expErr ? 32'h0 : rd;
      observeTxn(ackWait, rd, 1'b0, o);
      vectors++; if ({o.iGrant, o.dGrant} !== {!dataWins, dataWins}) begin miscompares++; $display("[TB] FAIL rnd%0d_grant: got %b, expected %b", n, {o.iGrant, o.dGrant}, {!dataWins, dataWins}); end
      vectors++; if (o.memAddr !== expAddr || o.memWe !== expWe || o.memWdata !== expWdata) begin miscompares++; $display("[TB] FAIL rnd%0d_bus: addr=%h we=%b wdata=%h, expected %h %b %h", n, o.memAddr, o.memWe, o.memWdata, expAddr, expWe, expWdata); end
      vectors++; if (o.reqCycles != expCycles) begin miscompares++; $display("[TB] FAIL rnd%0d_cycles: got %0d, expected %0d", n, o.reqCycles, expCycles); end
      vectors++; if ({o.iDv, o.dDv, o.busErr} !== {!dataWins, dataWins, expErr}) begin miscompares++; $display("[TB] FAIL rnd%0d_valid: got %b, expected %b", n, {o.iDv, o.dDv, o.busErr}, {!dataWins, dataWins, expErr}); end
      vectors++; if (o.iRd !== lastI || o.dRd !== lastD) begin miscompares++; $display("[TB] FAIL rnd%0d_data: i=%h d=%h, expected i=%h d=%h", n, o.iRd, o.dRd, lastI, lastD); end
      vectors++; if (o.extraGrants != 0 || o.busyDone !== 1'b1 || o.idleDirty !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd%0d_state: extra=%0d busyDone=%b idleDirty=%b, expected 0 1 0", n, o.extraGrants, o.busyDone, o.idleDirty); end
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_starvation();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
